// File: rtl/uart_tx_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched_if
// Brief    : Byte-request bus between requesters and the UART TX scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Brief    : Round-robin arbiter sharing one UART TX line, paced by an
//            external baud pulse generator.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    uart_tx_sched_if.slave       bus,
    input  wire logic            i_baud_pulse,
    output logic                 o_baud_en,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic [ID_W-1:0]      o_grant_id
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [7:0]          r_shift;
    logic                r_par;
    logic [2:0]          r_bit_cnt;
    logic                r_stop_cnt;
    logic [ID_W-1:0]     r_last_grant;

    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic [7:0]          w_byte;
    logic [NUM_REQ-1:0]  w_ready;
    logic                w_xfer;
    int                  w_best;

    // Winner is the valid requester with the smallest rotational distance
    // from the slot after the last grant.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_best   = NUM_REQ;
        w_byte   = '0;
        w_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] &&
                (((i + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ) < w_best)) begin
                w_best   = (i + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
                w_winner = ID_W'(i);
                w_found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_found && (w_winner == ID_W'(i))) begin
                w_byte     = bus.req_data[8*i +: 8];
                w_ready[i] = rst_n && (r_state == ST_IDLE);
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign w_xfer        = |(bus.req_valid & w_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            o_grant_id   <= '0;
            o_tx         <= 1'b1;
            o_baud_en    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_shift      <= w_byte;
                        r_par        <= (^w_byte) ^ (PARITY_ODD != 0);
                        o_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        o_tx         <= 1'b0;
                        o_baud_en    <= 1'b1;
                        o_busy       <= 1'b1;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_baud_pulse) begin
                        o_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_baud_pulse) begin
                        if (r_bit_cnt == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                o_tx    <= r_par;
                                r_state <= ST_PARITY;
                            end else begin
                                o_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= ST_STOP;
                            end
                        end else begin
                            r_shift   <= r_shift >> 1;
                            o_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (i_baud_pulse) begin
                        o_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Dropping baud_en here restarts the generator phase for the next frame.
                    if (i_baud_pulse) begin
                        if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                            o_baud_en <= 1'b0;
                            o_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    o_tx      <= 1'b1;
                    o_baud_en <= 1'b0;
                    o_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Brief    : Randomised self-checking bench; three parameterisations checked
//            against a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int GEN_N   [3] = '{10, 6, 7};
    localparam int PAR_EN  [3] = '{0, 1, 1};
    localparam int PAR_ODD [3] = '{0, 0, 1};
    localparam int STOPS   [3] = '{1, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [3:0]  tb_valid = '0;
    logic [31:0] tb_data = '0;
    logic        stray = 1'b0;

    logic [2:0]  pulse, ben, txv, busyv;
    logic [1:0]  gid0, gid1, gid2;
    int          cnt [3];

    int n_checks = 0;
    int n_fail   = 0;
    int last_g  [3];
    int exp_gid [3];

    logic        tx_m, busy_m, ben_m;
    logic [1:0]  gid_m;
    logic [3:0]  ready_m;

    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(4)) bus0 ();
    uart_tx_sched_if #(.NUM_REQ(4)) bus1 ();
    uart_tx_sched_if #(.NUM_REQ(4)) bus2 ();

    assign bus0.req_valid = (sel == 2'd0) ? tb_valid : 4'b0;
    assign bus1.req_valid = (sel == 2'd1) ? tb_valid : 4'b0;
    assign bus2.req_valid = (sel == 2'd2) ? tb_valid : 4'b0;
    assign bus0.req_data  = tb_data;
    assign bus1.req_data  = tb_data;
    assign bus2.req_data  = tb_data;

    uart_tx_sched #(.NUM_REQ(4), .ID_W(2), .STOP_BITS(STOPS[0]),
                    .PARITY_EN(PAR_EN[0]), .PARITY_ODD(PAR_ODD[0])) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .i_baud_pulse(pulse[0]),
        .o_baud_en(ben[0]), .o_tx(txv[0]), .o_busy(busyv[0]), .o_grant_id(gid0));

    uart_tx_sched #(.NUM_REQ(4), .ID_W(2), .STOP_BITS(STOPS[1]),
                    .PARITY_EN(PAR_EN[1]), .PARITY_ODD(PAR_ODD[1])) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .i_baud_pulse(pulse[1]),
        .o_baud_en(ben[1]), .o_tx(txv[1]), .o_busy(busyv[1]), .o_grant_id(gid1));

    uart_tx_sched #(.NUM_REQ(4), .ID_W(2), .STOP_BITS(STOPS[2]),
                    .PARITY_EN(PAR_EN[2]), .PARITY_ODD(PAR_ODD[2])) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .i_baud_pulse(pulse[2]),
        .o_baud_en(ben[2]), .o_tx(txv[2]), .o_busy(busyv[2]), .o_grant_id(gid2));

    // Baud generators: one pulse every GEN_N clocks of continuous enable.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!ben[i] || cnt[i] == GEN_N[i] - 1) cnt[i] <= 0;
            else                                   cnt[i] <= cnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            pulse[i] = (ben[i] && cnt[i] == GEN_N[i] - 1) || (stray && sel == 2'(i));
    end

    always_comb begin
        tx_m   = txv[sel];
        busy_m = busyv[sel];
        ben_m  = ben[sel];
        case (sel)
            2'd0:    begin gid_m = gid0; ready_m = bus0.req_ready; end
            2'd1:    begin gid_m = gid1; ready_m = bus1.req_ready; end
            default: begin gid_m = gid2; ready_m = bus2.req_ready; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++)
            if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            last_g[i]  = 3;
            exp_gid[i] = 0;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_tx",    32'(tx_m),    32'd1);
        check("rst_busy",  32'(busy_m),  32'd0);
        check("rst_ben",   32'(ben_m),   32'd0);
        check("rst_gid",   32'(gid_m),   32'd0);
        check("rst_ready", 32'(ready_m), 32'd0);
    endtask

    // Caller sits in the low clock phase with the DUT idle and inputs applied.
    task automatic do_frame(input int cfg, input int abort_cyc, input bit mutate);
        int         w, nb, ones;
        logic [7:0] b;
        logic       bits [16];
        #1;
        w = rr_pick(tb_valid, last_g[cfg]);
        check("ready_idle",   32'(ready_m), (w < 0) ? 32'd0 : (32'd1 << w));
        check("ready_onehot", 32'($countones(ready_m) <= 1), 32'd1);
        check("idle_tx",      32'(tx_m),   32'd1);
        check("idle_busy",    32'(busy_m), 32'd0);
        check("idle_ben",     32'(ben_m),  32'd0);
        check("idle_gid",     32'(gid_m),  32'(exp_gid[cfg]));
        if (w < 0) return;
        b    = tb_data[8*w +: 8];
        ones = $countones(b);
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1+k] = b[k];
        nb = 9;
        if (PAR_EN[cfg] != 0) begin
            bits[9] = (PAR_ODD[cfg] != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            nb = 10;
        end
        for (int s = 0; s < STOPS[cfg]; s++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        last_g[cfg]  = w;
        exp_gid[cfg] = w;
        @(posedge clk);
        if (mutate) begin
            #1;
            tb_data[8*w +: 8] = b ^ 8'($urandom_range(1, 255));
        end
        for (int c = 0; c < nb * GEN_N[cfg]; c++) begin
            @(negedge clk);
            if (abort_cyc > 0 && c == abort_cyc) return;
            check("frame_tx",    32'(tx_m),    32'(bits[c / GEN_N[cfg]]));
            check("frame_busy",  32'(busy_m),  32'd1);
            check("frame_ben",   32'(ben_m),   32'd1);
            check("frame_gid",   32'(gid_m),   32'(w));
            check("frame_ready", 32'(ready_m), 32'd0);
        end
        @(negedge clk);
        check("end_busy", 32'(busy_m), 32'd0);
        check("end_ben",  32'(ben_m),  32'd0);
        check("end_tx",   32'(tx_m),   32'd1);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        tb_valid = 4'hF;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        tb_valid = '0;
        rst_n    = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single byte from requester 2
        sel = 2'd0;
        tb_data[23:16] = 8'hA5;
        tb_valid = 4'b0100;
        do_frame(0, 0, 1'b0);
        tb_valid = '0;

        // Round robin from reset with all requesters valid
        @(negedge clk);
        apply_reset();
        tb_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        tb_valid = 4'hF;
        for (int f = 0; f < 5; f++) begin
            check("rr_order", 32'(rr_pick(tb_valid, last_g[0])), 32'(f % 4));
            do_frame(0, 0, 1'b0);
        end
        tb_valid = '0;

        // Stray baud pulses while idle
        stray = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stray_busy", 32'(busy_m), 32'd0);
            check("stray_tx",   32'(tx_m),   32'd1);
            check("stray_gid",  32'(gid_m),  32'(exp_gid[0]));
        end
        stray = 1'b0;

        // Random masks and bytes; data rewritten mid-frame
        for (int f = 0; f < 5; f++) begin
            tb_data  = $urandom;
            tb_valid = 4'($urandom_range(1, 15));
            do_frame(0, 0, 1'($urandom_range(0, 1)));
        end
        tb_valid = '0;

        // Reset in the middle of data bit 4
        tb_data[23:16] = 8'($urandom);
        tb_valid = 4'b0100;
        do_frame(0, 5 * GEN_N[0] + GEN_N[0] / 2, 1'b0);
        apply_reset();
        tb_data  = $urandom;
        tb_valid = 4'($urandom_range(0, 15)) | 4'b0001;
        check("post_rst_pick", 32'(rr_pick(tb_valid, last_g[0])), 32'd0);
        do_frame(0, 0, 1'b0);

        // Withdrawn request: 1 offered then dropped before the edge
        tb_valid = 4'b1010;
        #1;
        check("wd_ready_a", 32'(ready_m), 32'b0010);
        tb_valid = 4'b1000;
        do_frame(0, 0, 1'b0);
        tb_valid = '0;

        // Parity configurations, fixed byte 8'h07 then random bytes
        for (int cfg = 1; cfg < 3; cfg++) begin
            sel = 2'(cfg);
            @(negedge clk);
            tb_data  = {4{8'h07}};
            tb_valid = 4'($urandom_range(1, 15));
            do_frame(cfg, 0, 1'b0);
            for (int f = 0; f < 3; f++) begin
                tb_data  = $urandom;
                tb_valid = 4'($urandom_range(1, 15));
                do_frame(cfg, 0, 1'b1);
            end
            tb_valid = '0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmit line between NUM_REQ byte requesters. It arbitrates among valid requests and accepts one byte per frame. It drives the enable of the shared baud pulse generator and uses each returned baud pulse to step through start, data, optional parity and stop bits. It sits between the on-chip byte sources (LED status, command echo, debug) and the board TX pin.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ
STOP_BITS, 1, stop bits per frame (1 or 2)
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, with PARITY_EN=1: 0 selects even parity, 1 selects odd parity

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i]
req_ready  out  NUM_REQ  combinational; at most one bit high; a transfer occurs on a rising edge where valid[i]&ready[i]
baud_en  out  1  registered; enable to the baud pulse generator
baud_pulse  in  1  one-cycle pulse, one per bit period while baud_en=1
tx  out  1  registered serial output, idle high
busy  out  1  registered; high while a frame is in progress
grant_id  out  ID_W  registered; index of the requester whose frame is in progress or was last sent

Behaviour:
- Reset (async, any state, including mid-frame): state=IDLE, tx=1, baud_en=0, busy=0, grant_id=0, last_grant=NUM_REQ-1, bit/stop counters=0. req_ready=0 while rst_n=0. Any frame in progress is abandoned, with no further tx toggles.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, baud_en=0, busy=0.
  - Winner = first i with req_valid[i]=1, searching from (last_grant+1) mod NUM_REQ upward with wrap. req_ready[winner]=1; all other bits are 0.
  - With no valid request, req_ready=0.
  - A requester may drop valid without a transfer. Ready follows combinationally.
- Transfer edge:
  - shift register <= req_data[winner]
  - parity bit <= ^data XOR PARITY_ODD
  - grant_id <= winner, last_grant <= winner
  - tx <= 0, baud_en <= 1, busy <= 1, state <= START
- baud_pulse is ignored in IDLE.
- START: on baud_pulse, tx <= data[0], bit_cnt <= 0, state <= DATA.
- DATA: on baud_pulse:
  - If bit_cnt=7: go to PARITY with tx <= parity bit when PARITY_EN=1; otherwise go to STOP with tx <= 1, stop_cnt <= 0.
  - Else: shift right, tx <= next bit (LSB first), bit_cnt+1.
- PARITY: on baud_pulse, tx <= 1, stop_cnt <= 0, state <= STOP.
- STOP: tx=1. On baud_pulse:
  - If stop_cnt=STOP_BITS-1: state <= IDLE, baud_en <= 0, busy <= 0.
  - Else: stop_cnt+1.
- Between pulses, all state and tx hold. baud_en stays high continuously from the START edge through the final stop pulse.
- Timing with a generator period of N clocks: each bit lasts N cycles from the edge where tx changes. Frame = (1+8+PARITY_EN+STOP_BITS)*N cycles.
- Back-to-back: the earliest next transfer is one cycle after returning to IDLE. The last stop bit therefore lasts N+1 cycles, and baud_en is low for at least 1 cycle, which restarts the generator phase.
- req_valid/req_data changes during a frame have no effect; the byte is captured at the transfer edge.
- Fairness: with all requesters valid continuously, grants rotate 0,1,...,NUM_REQ-1,0,...

Test Plan:
1. Single byte: N=10, STOP_BITS=1, PARITY_EN=0; req_valid[2]=1, data 8'hA5.
   - Requires: req_ready[2] high 1 cycle, grant_id=2.
   - tx sequence 0,1,0,1,0,0,1,0,1,1, each 10 cycles (100-cycle frame).
   - busy=1 for exactly 100 cycles; baud_en falls with busy.
2. Round-robin: all 4 valid continuously, data = 8'h10+i.
   - Requires: grant order 0,1,2,3,0.
   - Each frame starts 1 cycle after the previous busy falls; the idle gap at tx=1 is 1 cycle.
3. Parity: PARITY_EN=1.
   - Even parity, data 8'h07: parity bit=1.
   - PARITY_ODD=1, same data: parity bit=0.
   - Frame is 11*N cycles with STOP_BITS=1, 12*N cycles with STOP_BITS=2.
4. Stray pulses: drive baud_pulse high in IDLE and toggle req_data of the active requester mid-frame.
   - Requires: no state change in IDLE; transmitted byte equals the value captured at the transfer edge.
5. Reset mid-frame: assert rst_n=0 during DATA bit 4.
   - Requires: tx=1, baud_en=0, busy=0, grant_id=0 immediately (asynchronously).
   - After release with req_valid[0]=1: the first grant goes to requester 0 and a full frame is sent.
6. Withdrawn request: req_valid[1] high for 0 cycles coincident with IDLE (dropped before an edge) while req_valid[3]=1.
   - Requires: transfer to requester 3 only; req_ready never shows two bits high.
